// File: rtl/signal_measure_if.sv
// Bundle of sample-stream inputs and registered measurement results for signal_measure.
`default_nettype none

interface signal_measure_if #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 16
);
  logic              enable;
  logic              frame_start;
  logic              sample_valid;
  logic [DATA_W-1:0] sample;
  logic [DATA_W-1:0] threshold;
  logic [DATA_W-1:0] max_out;
  logic [DATA_W-1:0] min_out;
  logic [DATA_W-1:0] mean_out;
  logic [DATA_W-1:0] p2p_out;
  logic [CNT_W-1:0]  period_out;
  logic              meas_valid;

  modport slave (
    input  enable, frame_start, sample_valid, sample, threshold,
    output max_out, min_out, mean_out, p2p_out, period_out, meas_valid
  );

  modport master (
    output enable, frame_start, sample_valid, sample, threshold,
    input  max_out, min_out, mean_out, p2p_out, period_out, meas_valid
  );
endinterface

`default_nettype wire

// File: rtl/signal_measure.sv
// Per-frame max/min/mean/peak-to-peak and rising-crossing period of an ADC sample stream.
`default_nettype none

module signal_measure #(
  parameter int DATA_W    = 12,
  parameter int FRAME_LEN = 256,
  parameter int CNT_W     = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  signal_measure_if.slave   if_meas
);
  localparam int LOG2_N = $clog2(FRAME_LEN);
  localparam int SUM_W  = DATA_W + LOG2_N;
  localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(FRAME_LEN - 1);
  localparam logic [0:0] S_ACCUM   = 1'b0;
  localparam logic [0:0] S_PUBLISH = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic              w_publish;

  logic [SUM_W-1:0]  r_sum;
  logic [DATA_W-1:0] r_max, r_min, r_prev;
  logic [LOG2_N-1:0] r_idx, r_last_x, r_prev_x;
  logic              r_have_prev;
  logic [1:0]        r_cnt;

  logic [SUM_W-1:0]  r_snap_sum;
  logic [DATA_W-1:0] r_snap_max, r_snap_min;
  logic [LOG2_N-1:0] r_snap_last_x, r_snap_prev_x;
  logic [1:0]        r_snap_cnt;

  logic              w_accept, w_clear, w_rise, w_last;
  logic [SUM_W-1:0]  w_b_sum, w_n_sum;
  logic [DATA_W-1:0] w_b_max, w_b_min, w_n_max, w_n_min;
  logic [LOG2_N-1:0] w_b_idx, w_n_last_x, w_n_prev_x;
  logic              w_b_have_prev;
  logic [1:0]        w_b_cnt, w_n_cnt;

  // frame_start first reduces the live state to its initial value, so a
  // coincident accepted sample lands as idx 0 of the fresh frame.
  always_comb begin
    w_accept      = if_meas.enable & if_meas.sample_valid;
    w_clear       = if_meas.frame_start;
    w_b_sum       = w_clear ? '0 : r_sum;
    w_b_max       = w_clear ? '0 : r_max;
    w_b_min       = w_clear ? '1 : r_min;
    w_b_idx       = w_clear ? '0 : r_idx;
    w_b_have_prev = w_clear ? 1'b0 : r_have_prev;
    w_b_cnt       = w_clear ? 2'd0 : r_cnt;
    w_rise        = w_b_have_prev && (r_prev < if_meas.threshold)
                    && (if_meas.sample >= if_meas.threshold);
    w_n_sum       = w_b_sum + SUM_W'(if_meas.sample);
    w_n_max       = (if_meas.sample > w_b_max) ? if_meas.sample : w_b_max;
    w_n_min       = (if_meas.sample < w_b_min) ? if_meas.sample : w_b_min;
    w_n_cnt       = w_b_cnt;
    w_n_last_x    = r_last_x;
    w_n_prev_x    = r_prev_x;
    if (w_rise) begin
      w_n_cnt    = (w_b_cnt == 2'd2) ? 2'd2 : 2'(w_b_cnt + 2'd1);
      w_n_last_x = w_b_idx;
      w_n_prev_x = r_last_x;
    end
    w_last        = w_accept && (w_b_idx == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_ACCUM;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ACCUM:   if (w_last) w_state_nxt = S_PUBLISH;
      S_PUBLISH: w_state_nxt = S_ACCUM;
      default:   w_state_nxt = S_ACCUM;
    endcase
  end

  always_comb begin
    w_publish = (r_state == S_PUBLISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0; r_max <= '0; r_min <= '1; r_prev <= '0;
      r_idx <= '0; r_last_x <= '0; r_prev_x <= '0;
      r_have_prev <= 1'b0; r_cnt <= 2'd0;
      r_snap_sum <= '0; r_snap_max <= '0; r_snap_min <= '0;
      r_snap_last_x <= '0; r_snap_prev_x <= '0; r_snap_cnt <= 2'd0;
    end else if (w_last) begin
      r_snap_sum    <= w_n_sum;
      r_snap_max    <= w_n_max;
      r_snap_min    <= w_n_min;
      r_snap_last_x <= w_n_last_x;
      r_snap_prev_x <= w_n_prev_x;
      r_snap_cnt    <= w_n_cnt;
      r_sum <= '0; r_max <= '0; r_min <= '1; r_prev <= '0;
      r_idx <= '0; r_last_x <= '0; r_prev_x <= '0;
      r_have_prev <= 1'b0; r_cnt <= 2'd0;
    end else if (w_accept) begin
      r_sum       <= w_n_sum;
      r_max       <= w_n_max;
      r_min       <= w_n_min;
      r_prev      <= if_meas.sample;
      r_idx       <= LOG2_N'(w_b_idx + 1'b1);
      r_last_x    <= w_n_last_x;
      r_prev_x    <= w_n_prev_x;
      r_have_prev <= 1'b1;
      r_cnt       <= w_n_cnt;
    end else if (w_clear) begin
      r_sum <= '0; r_max <= '0; r_min <= '1; r_prev <= '0;
      r_idx <= '0; r_last_x <= '0; r_prev_x <= '0;
      r_have_prev <= 1'b0; r_cnt <= 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_meas.max_out    <= '0;
      if_meas.min_out    <= '0;
      if_meas.mean_out   <= '0;
      if_meas.p2p_out    <= '0;
      if_meas.period_out <= '0;
      if_meas.meas_valid <= 1'b0;
    end else begin
      if_meas.meas_valid <= w_publish;
      if (w_publish) begin
        if_meas.max_out    <= r_snap_max;
        if_meas.min_out    <= r_snap_min;
        if_meas.mean_out   <= r_snap_sum[SUM_W-1:LOG2_N];
        if_meas.p2p_out    <= r_snap_max - r_snap_min;
        if_meas.period_out <= (r_snap_cnt == 2'd2)
                              ? CNT_W'(r_snap_last_x - r_snap_prev_x) : '0;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_signal_measure.sv
// Scoreboard bench for signal_measure: frame-level reference model feeds a queue, a monitor checks strobes and held outputs.
`default_nettype none

module tb_signal_measure;
  localparam int DW = 12;
  localparam int N  = 256;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  signal_measure_if #(.DATA_W(DW), .CNT_W(CW)) bus();

  signal_measure #(.DATA_W(DW), .FRAME_LEN(N), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .if_meas (bus.slave)
  );

  typedef struct {
    int mx; int mn; int mean; int p2p; int per; int edge_no;
  } exp_t;

  int   edge_cnt = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t cur = '{0, 0, 0, 0, 0, 0};
  int   fr_s[$];
  int   fr_t[$];
  int   th_r = 2048;

  always @(posedge clk) edge_cnt++;

  function automatic void check(string nm, int act, int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp_v, edge_cnt);
    end
  endfunction

  // Reference: collect a frame's accepted samples, then evaluate it whole.
  function automatic void model_step(bit en, bit fs, bit v, int s, int th);
    exp_t e;
    int sum, a, b;
    if (fs) begin fr_s.delete(); fr_t.delete(); end
    if (en && v) begin
      fr_s.push_back(s);
      fr_t.push_back(th);
      if (fr_s.size() == N) begin
        sum = 0; a = -1; b = -1;
        e.mx = 0; e.mn = (1 << DW) - 1;
        foreach (fr_s[i]) begin
          sum += fr_s[i];
          if (fr_s[i] > e.mx) e.mx = fr_s[i];
          if (fr_s[i] < e.mn) e.mn = fr_s[i];
          if (i > 0 && fr_s[i-1] < fr_t[i] && fr_s[i] >= fr_t[i]) begin
            a = b; b = i;
          end
        end
        e.mean = sum / N;
        e.p2p = e.mx - e.mn;
        e.per = (a >= 0) ? (b - a) : 0;
        e.edge_no = edge_cnt + 2;
        sb.push_back(e);
        fr_s.delete(); fr_t.delete();
      end
    end
  endfunction

  task automatic drive(input bit en, input bit fs, input bit v, input int s, input int th);
    bus.enable       = en;
    bus.frame_start  = fs;
    bus.sample_valid = v;
    bus.sample       = DW'(s);
    bus.threshold    = DW'(th);
    model_step(en, fs, v, s, th);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    bus.sample_valid = 1'b0;
    bus.frame_start  = 1'b0;
    rst_n = 1'b0;
    sb.delete(); fr_s.delete(); fr_t.delete();
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int sq(int k);
    return ((k / 16) % 2 == 1) ? 3000 : 1000;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      cur = '{0, 0, 0, 0, 0, 0};
      check("valid_in_reset", int'(bus.meas_valid), 0);
    end else if (bus.meas_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        cur = sb.pop_front();
        check("strobe_edge", edge_cnt, cur.edge_no);
      end
    end
    check("max_out",    int'(bus.max_out),    cur.mx);
    check("min_out",    int'(bus.min_out),    cur.mn);
    check("mean_out",   int'(bus.mean_out),   cur.mean);
    check("p2p_out",    int'(bus.p2p_out),    cur.p2p);
    check("period_out", int'(bus.period_out), cur.per);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int c;
    bit dis_done;
    bit en, fs, v;
    bus.enable = 1'b0; bus.frame_start = 1'b0; bus.sample_valid = 1'b0;
    bus.sample = '0; bus.threshold = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) drive(1, 0, 0, 0, 0);

    for (int i = 0; i < N; i++) drive(1, 0, 1, i, 4095);
    repeat (4) drive(1, 0, 0, 0, 4095);

    for (int i = 0; i < N; i++) drive(1, 0, 1, sq(i), 2048);
    for (int i = 0; i < N; i++) drive(1, 0, 1, 2048, 2048);
    repeat (2) drive(1, 0, 0, 0, 2048);

    for (int i = 0; i < 100; i++) drive(1, 0, 1, 4000, 2048);
    for (int i = 0; i < N; i++) drive(1, (i == 0), 1, 500, 2048);
    repeat (3) drive(1, 0, 0, 0, 2048);

    for (int i = 0; i < 150; i++) drive(1, 0, 1, 900 + i, 1000);
    do_reset(3);
    for (int i = 0; i < N; i++) drive(1, 0, 1, 700, 2048);
    repeat (3) drive(1, 0, 0, 0, 2048);

    k = 0; c = 0; dis_done = 1'b0;
    while (k < N) begin
      if (k == 100 && !dis_done) begin
        repeat (20) drive(0, 0, 1, 4095, 2048);
        dis_done = 1'b1;
      end else if (c % 3 == 0) begin
        drive(1, 0, 1, sq(k), 2048);
        k++;
      end else begin
        drive(1, 0, 0, 0, 2048);
      end
      c++;
    end
    repeat (4) drive(1, 0, 0, 0, 2048);

    for (int i = 0; i < 1600; i++) begin
      en = ($urandom_range(0, 7) != 0);
      v  = ($urandom_range(0, 3) != 0);
      fs = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 63) == 0) th_r = $urandom_range(0, 4095);
      drive(en, fs, v, $urandom_range(0, 4095), th_r);
    end
    for (int i = 0; i < 2 * N; i++) drive(1, 0, 1, $urandom_range(0, 4095), th_r);

    repeat (6) drive(1, 0, 0, 0, 2048);
    check("pending_strobes", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/signal_measure.md
# signal_measure

Streaming measurement engine for the oscilloscope datapath. It consumes the 12-bit ADC sample stream in frames of FRAME_LEN samples and computes per-frame maximum, minimum, mean, peak-to-peak and the rising-crossing period. It sits between the ADC/trigger capture path and font_gen, whose max/min/mean fields it feeds. Results are published with a single-cycle valid strobe and held until the next complete frame.

## Interface
Parameters:
- DATA_W, 12, sample width.
- FRAME_LEN, 256, samples per frame; power of two, at least 4.
- CNT_W, 16, width of the period output; must satisfy 2^CNT_W > FRAME_LEN.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  when 0, samples are ignored and the frame in progress is frozen, not cleared.
- frame_start  in  1  aborts the current frame and clears the accumulators.
- sample_valid  in  1  qualifies `sample` for one cycle.
- sample  in  DATA_W  unsigned ADC code.
- threshold  in  DATA_W  crossing level for period measurement; sampled on every accepted sample.
- max_out  out  DATA_W  frame maximum.
- min_out  out  DATA_W  frame minimum.
- mean_out  out  DATA_W  frame mean, truncated.
- p2p_out  out  DATA_W  max_out − min_out.
- period_out  out  CNT_W  samples between the last two rising crossings; 0 if the frame has fewer than two.
- meas_valid  out  1  one-cycle strobe; all outputs update on the same edge.

## Operation
- A sample is accepted when `enable && sample_valid`.
- States:
  - ACCUM: collecting samples.
  - PUBLISH: one cycle, driving the outputs.
- Reset enters ACCUM with the accumulators cleared.
- Accumulators:
  - sum: DATA_W+log2(FRAME_LEN) bits, 20 by default; it cannot overflow.
  - run_max: reset/init value 0.
  - run_min: reset/init value all-ones.
  - idx: sample index 0..FRAME_LEN−1.
  - prev: previous accepted sample, plus a have_prev flag.
  - last_x and prev_x: indices of the two most recent crossings, plus a crossing count saturating at 2.
- Rising crossing: `have_prev && prev < threshold && sample >= threshold`. The crossing index is the current idx. The first sample of a frame never counts as a crossing.
- On the accepted sample with idx = FRAME_LEN−1:
  - The final sum/min/max/crossing data, including this sample, is latched into snapshot registers.
  - All accumulators are reinitialised, so the next accepted sample is idx 0 of a new frame.
  - The FSM moves to PUBLISH.
- PUBLISH, on the next edge:
  - max_out ← snap_max; min_out ← snap_min.
  - mean_out ← snap_sum >> log2(FRAME_LEN).
  - p2p_out ← snap_max − snap_min (never negative).
  - period_out ← (count==2) ? last_x − prev_x : 0.
  - meas_valid ← 1; the FSM returns to ACCUM.
- Samples accepted while in PUBLISH go into the new frame normally, so back-to-back samples are never dropped.
- frame_start:
  - In ACCUM, it reinitialises the accumulators. If a sample is accepted in the same cycle, that sample becomes idx 0 of the new frame.
  - The aborted frame produces no meas_valid, and the outputs hold their old values.
  - In PUBLISH, the publish still completes; frame_start then clears the new frame.
- enable=0 with frame_start=1: frame_start still clears the accumulators.
- Reset values: every output is 0; the FSM is in ACCUM; the accumulators are initialised.
- Reset asserted mid-frame discards the frame; no meas_valid is produced.

## Timing
- Last sample of a frame presented in cycle with edge N:
  - Outputs and meas_valid change at edge N+1.
  - meas_valid is high for exactly one cycle and low at edge N+2.
- At most one meas_valid per FRAME_LEN accepted samples.
- Outputs are registered and stable between strobes.
- No combinational path from inputs to outputs.
- Idle gaps in sample_valid do not affect results.

## Test plan
- Ramp, sample=i for i=0..255, threshold=4095 → max 255, min 0, mean 127 (32640>>8), p2p 255, period 0; one meas_valid at the edge after sample 255.
- Square wave: 16×1000 then 16×3000, repeated for 256 samples, threshold=2048 → max 3000, min 1000, mean 2000, p2p 2000, period 32.
- Constant 2048, threshold=2048 → no crossing (no prev on the first sample, no rise after it); mean 2048, p2p 0, period 0.
- 100 samples of 4000, then frame_start coincident with the first of 256×500 → a single meas_valid with max=min=mean=500, p2p 0; no strobe for the aborted frame.
- rst low for 3 cycles after 150 samples → all outputs 0 and no strobe; the next 256 samples of 700 yield mean 700 with exactly one strobe.
- The square-wave stimulus with sample_valid every 3rd cycle, plus enable=0 for 20 cycles mid-frame → results identical to the back-to-back run; the strobe falls 1 edge after the 256th accepted sample.
